// File: rtl/vga_bg_cfg_writer.sv
// -----------------------------------------------------------------------------
// vga_bg_cfg_writer
//
// AXI4-Lite write master that pushes a 4-word configuration bundle into the
// vga_background register file (slv_reg0..slv_reg3). A bundle is accepted
// together with a per-register mask. The block optionally waits for vertical
// blanking so a frame is never drawn with half-updated settings, then issues
// one single-beat write per masked register, lowest index first. Only one
// write is outstanding at a time. A non-OKAY response sets a sticky error and
// abandons the rest of the bundle.
//
// Ports
//   ACLK, ARESET        clock, asynchronous active-high reset
//   cfg_valid/ready     bundle handshake (ready only while idle)
//   cfg_data            NUM_REGS words, word i at [DW*i +: DW]
//   cfg_mask            bit i set: write register i
//   vblank              vertical blanking, synchronous to ACLK
//   busy                bundle in progress
//   done                one-cycle pulse when a bundle completes
//   err                 sticky: a non-OKAY BRESP was seen in this bundle
//   M_AXI_AW*/W*/B*     AXI4-Lite write channels (read channel not present)
// -----------------------------------------------------------------------------
module vga_bg_cfg_writer #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 4,
  parameter int BASE_ADDR          = 0,
  parameter bit WAIT_VBLANK        = 1'b1
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
  input  logic [NUM_REGS-1:0]                    cfg_mask,
  input  logic                                   vblank,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                             M_AXI_AWPROT,
  output logic                                   M_AXI_AWVALID,
  input  logic                                   M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
  output logic                                   M_AXI_WVALID,
  input  logic                                   M_AXI_WREADY,
  input  logic [1:0]                             M_AXI_BRESP,
  input  logic                                   M_AXI_BVALID,
  output logic                                   M_AXI_BREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_VB = 3'd1,
    S_ISSUE   = 3'd2,
    S_RESP    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                   state_q,   state_d;
  logic [NUM_REGS*DW-1:0]   data_q,    data_d;
  logic [NUM_REGS-1:0]      mask_q,    mask_d;
  logic [IDX_W-1:0]         idx_q,     idx_d;
  logic [AW-1:0]            awaddr_q,  awaddr_d;
  logic [DW-1:0]            wdata_q,   wdata_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q,  wvalid_d;
  logic                     aw_ok_q,   aw_ok_d;
  logic                     w_ok_q,    w_ok_d;
  logic                     err_q,     err_d;

  logic                     launch;
  logic [NUM_REGS-1:0]      launch_mask;
  logic [NUM_REGS*DW-1:0]   launch_data;
  logic                     aw_fire;
  logic                     w_fire;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REGS-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic [AW-1:0] reg_addr(input logic [IDX_W-1:0] idx);
    reg_addr = AW'(BASE_ADDR + 4 * int'(idx));
  endfunction

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_ok_d     = aw_ok_q;
    w_ok_d      = w_ok_q;
    err_d       = err_q;
    launch      = 1'b0;
    launch_mask = mask_q;
    launch_data = data_q;
    aw_fire     = awvalid_q && M_AXI_AWREADY;
    w_fire      = wvalid_q && M_AXI_WREADY;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          data_d = cfg_data;
          mask_d = cfg_mask;
          err_d  = 1'b0;
          if (cfg_mask == '0) begin
            state_d = S_DONE;
          end else if (WAIT_VBLANK) begin
            state_d = S_WAIT_VB;
          end else begin
            launch      = 1'b1;
            launch_mask = cfg_mask;
            launch_data = cfg_data;
          end
        end
      end

      // vblank only gates the first write of a bundle
      S_WAIT_VB: begin
        if (vblank) launch = 1'b1;
      end

      // AW and W complete independently; each VALID drops after its own
      // handshake and the response phase starts once both are through.
      S_ISSUE: begin
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_ok_d   = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_ok_d   = 1'b1;
        end
        if ((aw_ok_q || aw_fire) && (w_ok_q || w_fire)) state_d = S_RESP;
      end

      S_RESP: begin
        if (M_AXI_BVALID) begin
          mask_d = mask_q & ~(NUM_REGS'(1) << idx_q);
          if (M_AXI_BRESP != 2'b00) err_d = 1'b1;
          // an error skips whatever registers are left in the bundle
          if (err_d || (mask_d == '0)) begin
            state_d = S_DONE;
          end else begin
            launch      = 1'b1;
            launch_mask = mask_d;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Address/data are registered on entry to ISSUE so VALID is high in the
    // very first ISSUE cycle.
    if (launch) begin
      state_d   = S_ISSUE;
      idx_d     = lowest_idx(launch_mask);
      awaddr_d  = reg_addr(idx_d);
      wdata_d   = launch_data[int'(idx_d)*DW +: DW];
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      aw_ok_d   = 1'b0;
      w_ok_d    = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_ok_q   <= aw_ok_d;
      w_ok_q    <= w_ok_d;
      err_q     <= err_d;
    end
  end

  // cfg_ready is masked by ARESET so nothing is offered as accepted while
  // the block is held in reset.
  assign cfg_ready     = (state_q == S_IDLE) && !ARESET;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == S_RESP);

endmodule

// File: tb/tb_vga_bg_cfg_writer.sv
// -----------------------------------------------------------------------------
// tb_vga_bg_cfg_writer
//
// Two instances of vga_bg_cfg_writer (WAIT_VBLANK=1 and WAIT_VBLANK=0) share
// one behavioural AXI4-Lite slave selected by 'sel'. Each bundle is predicted
// from the register-level rules (which writes happen, in what order, what
// the register file ends up holding, the error flag and the cycle cost) and
// compared with what the slave observed.
// -----------------------------------------------------------------------------
module tb_vga_bg_cfg_writer;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic            sel;
  logic [NR*DW-1:0] cfg_data;
  logic [NR-1:0]   cfg_mask;
  logic            vblank;

  logic            cfg_valid_i [2];
  logic            cfg_ready_o [2];
  logic            busy_o      [2];
  logic            done_o      [2];
  logic            err_o       [2];
  logic [AW-1:0]   awaddr_o    [2];
  logic [2:0]      awprot_o    [2];
  logic            awvalid_o   [2];
  logic            awready_i   [2];
  logic [DW-1:0]   wdata_o     [2];
  logic [3:0]      wstrb_o     [2];
  logic            wvalid_o    [2];
  logic            wready_i    [2];
  logic [1:0]      bresp_i     [2];
  logic            bvalid_i    [2];
  logic            bready_o    [2];

  vga_bg_cfg_writer #(.WAIT_VBLANK(1'b1)) dut0 (
    .ACLK(clk), .ARESET(rst),
    .cfg_valid(cfg_valid_i[0]), .cfg_ready(cfg_ready_o[0]),
    .cfg_data(cfg_data), .cfg_mask(cfg_mask), .vblank(vblank),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]),
    .M_AXI_AWADDR(awaddr_o[0]), .M_AXI_AWPROT(awprot_o[0]),
    .M_AXI_AWVALID(awvalid_o[0]), .M_AXI_AWREADY(awready_i[0]),
    .M_AXI_WDATA(wdata_o[0]), .M_AXI_WSTRB(wstrb_o[0]),
    .M_AXI_WVALID(wvalid_o[0]), .M_AXI_WREADY(wready_i[0]),
    .M_AXI_BRESP(bresp_i[0]), .M_AXI_BVALID(bvalid_i[0]),
    .M_AXI_BREADY(bready_o[0])
  );

  vga_bg_cfg_writer #(.WAIT_VBLANK(1'b0)) dut1 (
    .ACLK(clk), .ARESET(rst),
    .cfg_valid(cfg_valid_i[1]), .cfg_ready(cfg_ready_o[1]),
    .cfg_data(cfg_data), .cfg_mask(cfg_mask), .vblank(vblank),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]),
    .M_AXI_AWADDR(awaddr_o[1]), .M_AXI_AWPROT(awprot_o[1]),
    .M_AXI_AWVALID(awvalid_o[1]), .M_AXI_AWREADY(awready_i[1]),
    .M_AXI_WDATA(wdata_o[1]), .M_AXI_WSTRB(wstrb_o[1]),
    .M_AXI_WVALID(wvalid_o[1]), .M_AXI_WREADY(wready_i[1]),
    .M_AXI_BRESP(bresp_i[1]), .M_AXI_BVALID(bvalid_i[1]),
    .M_AXI_BREADY(bready_o[1])
  );

  // ---------------- behavioural AXI4-Lite slave ----------------
  logic [AW-1:0] s_awaddr;
  logic [2:0]    s_awprot;
  logic          s_awvalid, s_awready;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_wvalid, s_wready;
  logic          s_bvalid, s_bready;
  logic [1:0]    s_bresp;

  int            aw_dly, w_dly, aw_wait, w_wait;
  logic          aw_got, w_got;
  logic [AW-1:0] got_addr;
  logic [DW-1:0] got_data;
  logic [DW-1:0] mem [NR];
  logic [1:0]    resp_tbl [NR];
  int            wr_total, wr_base;
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];

  assign s_awaddr  = awaddr_o[sel];
  assign s_awprot  = awprot_o[sel];
  assign s_awvalid = awvalid_o[sel];
  assign s_wdata   = wdata_o[sel];
  assign s_wstrb   = wstrb_o[sel];
  assign s_wvalid  = wvalid_o[sel];
  assign s_bready  = bready_o[sel];

  assign s_awready = s_awvalid && !aw_got && (aw_wait >= aw_dly);
  assign s_wready  = s_wvalid && !w_got && (w_wait >= w_dly);
  assign s_bvalid  = aw_got && w_got;
  assign s_bresp   = resp_tbl[2'(wr_total - wr_base)];

  assign awready_i[0] = !sel && s_awready;
  assign awready_i[1] =  sel && s_awready;
  assign wready_i[0]  = !sel && s_wready;
  assign wready_i[1]  =  sel && s_wready;
  assign bvalid_i[0]  = !sel && s_bvalid;
  assign bvalid_i[1]  =  sel && s_bvalid;
  assign bresp_i[0]   = s_bresp;
  assign bresp_i[1]   = s_bresp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_wait  <= 0;
      w_wait   <= 0;
      wr_total <= 0;
      got_addr <= '0;
      got_data <= '0;
      for (int i = 0; i < NR; i++) mem[i] <= '0;
    end else begin
      if (s_awvalid && s_awready) begin
        aw_got   <= 1'b1;
        got_addr <= s_awaddr;
        aw_wait  <= 0;
      end else if (s_awvalid && !aw_got) begin
        aw_wait <= aw_wait + 1;
      end
      if (s_wvalid && s_wready) begin
        w_got    <= 1'b1;
        got_data <= s_wdata;
        w_wait   <= 0;
      end else if (s_wvalid && !w_got) begin
        w_wait <= w_wait + 1;
      end
      if (s_bvalid && s_bready) begin
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        wr_total <= wr_total + 1;
        log_addr.push_back(got_addr);
        log_data.push_back(got_data);
        if (s_bresp == 2'b00 && got_addr[1:0] == 2'b00) mem[got_addr[3:2]] <= got_data;
      end
    end
  end

  // ---------------- protocol / event monitor ----------------
  int            done_cnt = 0, busy_cnt = 0, aw_seen = 0, proto_viol = 0;
  logic          pa_stall = 1'b0, pw_stall = 1'b0, pa_valid = 1'b0;
  logic [AW-1:0] pa_addr = '0;
  logic [DW-1:0] pw_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      pa_stall = 1'b0;
      pw_stall = 1'b0;
      pa_valid = 1'b0;
    end else begin
      if (done_o[sel]) done_cnt++;
      if (busy_o[sel]) busy_cnt++;
      if (s_awvalid) aw_seen++;
      if (s_bready && !(aw_got && w_got)) proto_viol++;
      if (pa_stall && (!s_awvalid || s_awaddr !== pa_addr)) proto_viol++;
      if (pw_stall && (!s_wvalid || s_wdata !== pw_data)) proto_viol++;
      if (s_awvalid && !pa_valid && !s_wvalid) proto_viol++;
      if (s_awvalid && s_awprot !== 3'b000) proto_viol++;
      if (s_wvalid && s_wstrb !== 4'hF) proto_viol++;
      pa_stall = s_awvalid && !s_awready;
      pw_stall = s_wvalid && !s_wready;
      pa_addr  = s_awaddr;
      pw_data  = s_wdata;
      pa_valid = s_awvalid;
    end
  end

  // ---------------- helpers ----------------
  logic [DW-1:0] exp_mem [NR];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_bundle(input logic [NR*DW-1:0] d, input logic [NR-1:0] m,
                            input int vb_delay, input bit zero_wait, input string tag);
    logic [AW-1:0] ea [$];
    logic [DW-1:0] ed [$];
    logic          exp_err;
    int            log0, done0, busy0, aw0, viol0, cyc, exp_busy;

    // reference: masked registers in ascending order, stop after first error
    exp_err = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (m[i] && !exp_err) begin
        ea.push_back(AW'(4 * i));
        ed.push_back(d[DW*i +: DW]);
        if (resp_tbl[ea.size() - 1] != 2'b00) exp_err = 1'b1;
        else exp_mem[i] = d[DW*i +: DW];
      end
    end
    if (m == '0) exp_busy = 1;
    else exp_busy = 2 * ea.size() + 1 + (sel == 1'b0 ? 1 : 0);

    tick();
    check({tag, "_ready"}, cfg_ready_o[sel], 1'b1);
    log0  = log_addr.size();
    done0 = done_cnt;
    busy0 = busy_cnt;
    aw0   = aw_seen;
    viol0 = proto_viol;
    wr_base = wr_total;
    cfg_data = d;
    cfg_mask = m;
    vblank   = (vb_delay == 0);
    cfg_valid_i[sel] = 1'b1;
    tick();
    cyc = 1;
    check({tag, "_busy_after_accept"}, busy_o[sel], 1'b1);
    check({tag, "_err_cleared"}, err_o[sel], 1'b0);
    // a bundle offered while busy must be ignored
    cfg_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    cfg_mask = 4'hF;
    while (done_cnt == done0 && cyc < 2000) begin
      if (sel == 1'b0 && m != '0 && vb_delay > 0 && cyc == vb_delay) begin
        check({tag, "_no_aw_before_vblank"}, aw_seen - aw0, 0);
        vblank = 1'b1;
      end
      tick();
      cyc++;
      cfg_valid_i[sel] = 1'b0;
      if (sel == 1'b0 && m != '0 && vb_delay > 0 && cyc == vb_delay + 1)
        check({tag, "_aw_after_vblank"}, awvalid_o[sel], 1'b1);
      if (vb_delay > 0 && cyc >= vb_delay) vblank = 1'b1;
    end
    cfg_valid_i[sel] = 1'b0;
    check({tag, "_done_seen"}, done_cnt != done0, 1'b1);
    tick();
    check({tag, "_done_pulses"}, done_cnt - done0, 1);
    check({tag, "_idle"}, busy_o[sel], 1'b0);
    check({tag, "_err"}, err_o[sel], exp_err);
    check({tag, "_nwrites"}, log_addr.size() - log0, ea.size());
    for (int i = 0; i < ea.size(); i++) begin
      if (log0 + i < log_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), log_addr[log0 + i], ea[i]);
        check($sformatf("%s_data%0d", tag, i), log_data[log0 + i], ed[i]);
      end
    end
    for (int i = 0; i < NR; i++) check($sformatf("%s_reg%0d", tag, i), mem[i], exp_mem[i]);
    check({tag, "_protocol"}, proto_viol - viol0, 0);
    if (m == '0) check({tag, "_no_aw"}, aw_seen - aw0, 0);
    if (zero_wait && vb_delay == 0) check({tag, "_cycles"}, busy_cnt - busy0, exp_busy);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    m;
    int               vbd, cyc;

    sel = 1'b0; rst = 1'b0; vblank = 1'b1;
    cfg_data = '0; cfg_mask = '0;
    cfg_valid_i[0] = 1'b0; cfg_valid_i[1] = 1'b0;
    aw_dly = 0; w_dly = 0; wr_base = 0;
    for (int i = 0; i < NR; i++) begin
      resp_tbl[i] = 2'b00;
      exp_mem[i]  = '0;
    end
    #1 rst = 1'b1;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d_ready", k),   cfg_ready_o[k], 1'b0);
      check($sformatf("rst%0d_busy", k),    busy_o[k],      1'b0);
      check($sformatf("rst%0d_done", k),    done_o[k],      1'b0);
      check($sformatf("rst%0d_err", k),     err_o[k],       1'b0);
      check($sformatf("rst%0d_awvalid", k), awvalid_o[k],   1'b0);
      check($sformatf("rst%0d_wvalid", k),  wvalid_o[k],    1'b0);
      check($sformatf("rst%0d_bready", k),  bready_o[k],    1'b0);
      check($sformatf("rst%0d_awaddr", k),  awaddr_o[k],    4'h0);
      check($sformatf("rst%0d_wdata", k),   wdata_o[k],     32'h0);
    end
    rst = 1'b0;
    tick();

    // all four registers, no vblank wait, zero-wait slave
    sel = 1'b1;
    run_bundle({32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 0, 1'b1, "t1");

    // partial mask and empty mask
    run_bundle({$urandom(), $urandom(), $urandom(), $urandom()}, 4'b0101, 0, 1'b1, "t2_0101");
    run_bundle({$urandom(), $urandom(), $urandom(), $urandom()}, 4'b0000, 0, 1'b1, "t2_zero");

    // held off by vblank for 50 cycles
    sel = 1'b0;
    run_bundle({$urandom(), $urandom(), $urandom(), $urandom()}, 4'b1111, 50, 1'b0, "t3");

    // AWREADY late, WREADY less late
    aw_dly = 3; w_dly = 1;
    run_bundle({$urandom(), $urandom(), $urandom(), $urandom()}, 4'b1011, 0, 1'b0, "t4");

    // SLVERR on the second write
    aw_dly = 0; w_dly = 0;
    resp_tbl[1] = 2'b10;
    run_bundle({$urandom(), $urandom(), $urandom(), $urandom()}, 4'b1111, 0, 1'b1, "t5");
    resp_tbl[1] = 2'b00;
    run_bundle({$urandom(), $urandom(), $urandom(), $urandom()}, 4'b0110, 0, 1'b1, "t5_next");

    // reset while AWVALID is up
    sel = 1'b0; aw_dly = 30; vblank = 1'b1;
    cfg_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    cfg_mask = 4'b1111;
    cfg_valid_i[0] = 1'b1;
    tick();
    cfg_valid_i[0] = 1'b0;
    cyc = 0;
    while (!awvalid_o[0] && cyc < 10) begin
      tick();
      cyc++;
    end
    check("t6_aw_up", awvalid_o[0], 1'b1);
    rst = 1'b1;
    #1;
    check("t6_awvalid_dropped", awvalid_o[0], 1'b0);
    check("t6_wvalid_dropped",  wvalid_o[0],  1'b0);
    check("t6_busy_dropped",    busy_o[0],    1'b0);
    check("t6_ready_in_reset",  cfg_ready_o[0], 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("t6_ready_on_release", cfg_ready_o[0], 1'b1);
    tick();
    check("t6_ready_first_cycle", cfg_ready_o[0], 1'b1);
    for (int i = 0; i < NR; i++) exp_mem[i] = '0;
    aw_dly = 0;
    run_bundle({$urandom(), $urandom(), $urandom(), $urandom()}, 4'b1111, 0, 1'b1, "t6_recover");

    // randomized bundles
    for (int r = 0; r < 24; r++) begin
      sel    = 1'($urandom_range(0, 1));
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      for (int i = 0; i < NR; i++)
        resp_tbl[i] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d   = {$urandom(), $urandom(), $urandom(), $urandom()};
      m   = 4'($urandom_range(0, 15));
      vbd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      run_bundle(d, m, vbd, (aw_dly == 0 && w_dly == 0), $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
